// File: rtl/ai_result_buffer_pkg.sv
// rtl/ai_result_buffer_pkg.sv - register map, bit positions and response encodings for ai_result_buffer
package ai_resbuf_pkg;

  localparam logic [11:0] OFF_STATUS = 12'h000;
  localparam logic [11:0] OFF_CTRL   = 12'h004;
  localparam logic [11:0] OFF_POP    = 12'h008;
  localparam logic [11:0] OFF_WIN    = 12'h400;

  localparam int ST_FULL_BIT   = 0;
  localparam int ST_OVF_BIT    = 1;
  localparam int ST_IRQ_EN_BIT = 2;
  localparam int ST_RD_PTR_LSB = 8;

  localparam int CTRL_RELEASE_BIT = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT  = 2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    RESP_OKAY = 2'd0,
    RESP_ERR1 = 2'd1,
    RESP_ERR2 = 2'd2
  } resp_state_t;

endpackage

// File: rtl/ai_result_buffer_if.sv
// rtl/ai_result_buffer_if.sv - AHB-Lite slave bus bundle for ai_result_buffer
interface ai_result_buffer_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ai_result_buffer_ahb_slave_ctrl.sv
// rtl/ai_result_buffer_ahb_slave_ctrl.sv - address-phase capture, decode and 2-cycle ERROR response
module ai_ahb_slave_ctrl
  import ai_resbuf_pkg::*;
#(
  parameter int NWORDS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [11:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic        hready,
  input  logic        full_nxt,
  output logic        hreadyout,
  output logic        hresp,
  output logic        rd_stb,
  output logic        wr_stb,
  output logic        sel_status,
  output logic        sel_ctrl,
  output logic        sel_pop,
  output logic        sel_win,
  output logic [7:0]  win_idx
);

  resp_state_t state;
  logic        dp_ok;
  logic        dp_write;
  logic        accept;
  logic        a_status, a_ctrl, a_pop, a_win, a_err;

  assign accept   = hsel & hready & htrans[1] & (state != RESP_ERR1);
  assign a_status = (haddr == OFF_STATUS);
  assign a_ctrl   = (haddr == OFF_CTRL);
  assign a_pop    = (haddr == OFF_POP);
  assign a_win    = (haddr[11:10] == OFF_WIN[11:10]) && (haddr[1:0] == 2'b00)
                    && ({1'b0, haddr[9:2]} < 9'(NWORDS));

  // full_nxt is the value full will hold during this transfer's data phase,
  // so an empty POP is known one cycle early and the response stays registered.
  assign a_err = ~(a_status | a_ctrl | a_pop | a_win)
               | (hwrite ^ a_ctrl)
               | (~hwrite & a_pop & ~full_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESP_OKAY;
      hreadyout  <= 1'b1;
      hresp      <= HRESP_OKAY;
      dp_ok      <= 1'b0;
      dp_write   <= 1'b0;
      sel_status <= 1'b0;
      sel_ctrl   <= 1'b0;
      sel_pop    <= 1'b0;
      sel_win    <= 1'b0;
      win_idx    <= '0;
    end else if (accept) begin
      dp_ok      <= ~a_err;
      dp_write   <= hwrite;
      sel_status <= a_status;
      sel_ctrl   <= a_ctrl;
      sel_pop    <= a_pop;
      sel_win    <= a_win;
      win_idx    <= haddr[9:2];
      state      <= a_err ? RESP_ERR1 : RESP_OKAY;
      hreadyout  <= ~a_err;
      hresp      <= a_err ? HRESP_ERROR : HRESP_OKAY;
    end else begin
      dp_ok <= 1'b0;
      if (state == RESP_ERR1) begin
        state     <= RESP_ERR2;
        hreadyout <= 1'b1;
        hresp     <= HRESP_ERROR;
      end else begin
        state     <= RESP_OKAY;
        hreadyout <= 1'b1;
        hresp     <= HRESP_OKAY;
      end
    end
  end

  assign rd_stb = dp_ok & ~dp_write;
  assign wr_stb = dp_ok & dp_write;

endmodule

// File: rtl/ai_result_buffer.sv
// rtl/ai_result_buffer.sv - captures the transformer output vector and serves it as 32-bit AHB words
// Optional feature macro: AI_RESBUF_IRQ_EN (irq_en register and irq output).
module ai_result_buffer
  import ai_resbuf_pkg::*;
#(
  parameter int IDIM  = 512,
  parameter int WIDTH = 8
) (
  input  logic                  ahb_hclk,
  input  logic                  ahb_hresetn,
  ai_result_buffer_if.slave     ahb,
  input  logic                  done,
  input  logic [IDIM*WIDTH-1:0] output_data,
  output logic                  ai_valid,
  output logic                  irq
);

  localparam int NWORDS = IDIM * WIDTH / 32;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [31:0] buf_mem [NWORDS];
  logic        full, ovf, done_q, irq_en;
  logic [7:0]  rd_ptr;

  logic        rd_stb, wr_stb, sel_status, sel_ctrl, sel_pop, sel_win;
  logic [7:0]  win_idx;
  logic        cap, ctrl_wr, pop, release_ev, clr_ovf, final_pop;
  logic        full_kept, cap_load, full_nxt;
  logic [31:0] status_word, rdata;
  logic        unused_bits;

  ai_ahb_slave_ctrl #(.NWORDS(NWORDS)) u_ctrl (
    .clk        (ahb_hclk),
    .rst_n      (ahb_hresetn),
    .hsel       (ahb.hsel),
    .haddr      (ahb.haddr[11:0]),
    .htrans     (ahb.htrans),
    .hwrite     (ahb.hwrite),
    .hready     (ahb.hready),
    .full_nxt   (full_nxt),
    .hreadyout  (ahb.hreadyout),
    .hresp      (ahb.hresp),
    .rd_stb     (rd_stb),
    .wr_stb     (wr_stb),
    .sel_status (sel_status),
    .sel_ctrl   (sel_ctrl),
    .sel_pop    (sel_pop),
    .sel_win    (sel_win),
    .win_idx    (win_idx)
  );

  assign unused_bits = ^{ahb.haddr[31:12], ahb.hwdata[31:2]};

  assign cap        = done & ~done_q;
  assign ctrl_wr    = wr_stb & sel_ctrl;
  assign pop        = rd_stb & sel_pop;
  assign release_ev = ctrl_wr & ahb.hwdata[CTRL_RELEASE_BIT];
  assign clr_ovf    = ctrl_wr & ahb.hwdata[CTRL_CLR_OVF_BIT];
  assign final_pop  = pop & (rd_ptr == 8'(NWORDS - 1));

  // Release / final pop take effect before a same-cycle capture is judged.
  assign full_kept = full & ~release_ev & ~final_pop;
  assign cap_load  = cap & ~full_kept;
  assign full_nxt  = full_kept | cap;

  always_ff @(posedge ahb_hclk or negedge ahb_hresetn) begin
    if (!ahb_hresetn) begin
      full   <= 1'b0;
      ovf    <= 1'b0;
      rd_ptr <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done;
      full   <= full_nxt;
      ovf    <= (ovf & ~clr_ovf) | (cap & full_kept);
      if (cap_load || release_ev || final_pop)
        rd_ptr <= '0;
      else if (pop)
        rd_ptr <= rd_ptr + 8'd1;
    end
  end

  always_ff @(posedge ahb_hclk) begin
    if (cap_load) begin
      for (int i = 0; i < NWORDS; i++)
        buf_mem[i] <= output_data[32*i +: 32];
    end
  end

`ifdef AI_RESBUF_IRQ_EN
  always_ff @(posedge ahb_hclk or negedge ahb_hresetn) begin
    if (!ahb_hresetn)
      irq_en <= 1'b0;
    else if (ctrl_wr)
      irq_en <= ahb.hwdata[CTRL_IRQ_EN_BIT];
  end
  assign irq = irq_en & full;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    status_word                          = '0;
    status_word[ST_FULL_BIT]             = full;
    status_word[ST_OVF_BIT]              = ovf;
    status_word[ST_IRQ_EN_BIT]           = irq_en;
    status_word[ST_RD_PTR_LSB +: 8]      = rd_ptr;
  end

  // Data-phase read mux reflects state before this transfer's side effects.
  always_comb begin
    rdata = '0;
    if (rd_stb) begin
      if (sel_status)
        rdata = status_word;
      else if (sel_pop)
        rdata = buf_mem[rd_ptr[IW-1:0]];
      else if (sel_win)
        rdata = buf_mem[win_idx[IW-1:0]];
    end
  end

  assign ahb.hrdata = rdata;
  assign ai_valid   = full;

endmodule
